gb_cpu_core: RTL and testbench
==============================

Name: gb_cpu_core

Overview:
- 8-bit CPU core implementing a subset of the Game Boy (SM83) instruction set.
- Sits between a flat 64 KiB byte memory (combinational read, clocked write) and the system top.
- Exposes architectural state on debug ports for bring-up and verification.
- Multi-cycle FSM; one memory access per clock.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- RESET_SP, 16'hFFFE, SP value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_addr  output  16  byte address; combinational from FSM state and registers.
- mem_data_write  output  8  store data, valid while mem_do_write=1.
- mem_data_read  input  8  read data; combinational (same-cycle) function of mem_addr.
- mem_do_write  output  1  store strobe; memory writes at the rising edge while high.
- halted  output  1  high once HALT executes; cleared only by reset.
- dbg_pc  output  16  current PC.
- dbg_F  output  4  flags {Z,N,H,C} (F[7:4]).
- dbg_A, dbg_B, dbg_C  output  8 each  register contents.
- dbg_instruction_retired  output  1  one-cycle pulse per completed instruction.

Behaviour:
- State: A,B,C,D,E,H,L,F (low nibble always 0), SP, PC, IR, temp byte, FSM state.
- Reset (async) values: PC=RESET_PC, SP=RESET_SP, all other registers 0, FSM=FETCH, halted=0, dbg_instruction_retired=0, mem_do_write=0.
- FETCH: mem_addr=PC; IR<=mem_data_read; PC<=PC+1.
- IMM states: mem_addr=PC; PC<=PC+1.
- MEM state: mem_addr=HL or the a16 operand.
- Cycle counts:
  - NOP, HALT, LD r,r', ALU A,r, INC r, DEC r: 2 (FETCH, EXEC).
  - LD r,(HL) and LD (HL),r: 2 (FETCH, MEM).
  - LD r,d8; ALU A,d8; JR e8 and JR cc,e8 (taken or not): 2.
  - LD rr,d16 (01/11/21/31) and JP a16 (C3): 3.
  - LD (a16),A (EA) and LD A,(a16) (FA): 4.
- Supported opcodes:
  - 00; 76; LD r,d8 (06/0E/16/1E/26/2E/3E).
  - 40–7F except 76; r=6 selects (HL).
  - 80–BF as ADD/ADC/SUB/SBC/AND/XOR/OR/CP A,r; (HL) source reads memory in the MEM state.
  - C6/CE/D6/DE/E6/EE/F6/FE.
  - INC r / DEC r (x4/x5/xC/xD) for registers only.
  - 18, 20, 28, 30, 38, C3, EA, FA, 01, 11, 21, 31.
- All other opcodes execute as 1-byte NOP (2 cycles).
- JR: target = PC after operand + sign-extended e8, 16-bit wrap.
- Conditions: NZ/Z/NC/C per the Z and C flags.
- 16-bit operands are little-endian.
- Flags:
  - ADD/ADC: Z=(res==0), N=0, H=carry out of bit 3, C=carry out of bit 7.
  - SUB/SBC/CP: N=1, H=borrow from bit 4, C=borrow; CP discards the result.
  - AND: H=1, N=0, C=0. OR/XOR: N=H=C=0. Z set per result in all cases.
  - INC: N=0, H=(low nibble 0xF→0), C unchanged.
  - DEC: N=1, H=(low nibble 0→F), C unchanged.
- mem_do_write is high only in the MEM cycle of LD (HL),r and EA.
- dbg_instruction_retired is registered: high for exactly one clock after the edge that commits an instruction. Debug ports show post-instruction values in that cycle.
- HALT: on its EXEC edge, halted<=1 and retired pulses.
  - FSM then freezes: PC points past the HALT opcode, mem_do_write=0, no further retire pulses.
- Reset asserted mid-instruction aborts it immediately: no partial register or memory commit after reset assertion.

Test Plan:
- Reset held, then released → PC=0000, A=B=C=00, dbg_F=0000, halted=0, mem_do_write=0, first mem_addr=0000.
- Program 3E 05 06 03 80 76 → A=08, B=03, dbg_F=0000, four retire pulses, halted=1, dbg_pc=0006 stable.
- 3E 0F C6 01 76 → A=10, dbg_F=0010. Separately 3E FF C6 01 76 → A=00, dbg_F=1011.
- 21 40 00 3E AA 77 76 → single-cycle mem_do_write with mem_addr=0040, data=AA; then 7E into C via 4E gives C=AA.
- 06 03 05 20 FD 76 → loop runs 3 times, B=00, dbg_F=1100, halted=1.
- Assert reset during the IMM cycle of 3E 77 → A stays 00, PC=0000 after release, program re-executes giving A=77.

Source files
------------

// File: rtl/gb_cpu_core.sv
// Multi-cycle SM83 (Game Boy) subset core: one memory access per clock, flat byte memory,
// architectural state mirrored on debug ports.
module gb_cpu_core #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] RESET_SP = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_write,
    input  logic [7:0]  mem_data_read,
    output logic        mem_do_write,
    output logic        halted,
    output logic [15:0] dbg_pc,
    output logic [3:0]  dbg_F,
    output logic [7:0]  dbg_A,
    output logic [7:0]  dbg_B,
    output logic [7:0]  dbg_C,
    output logic        dbg_instruction_retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_EXEC, S_IMM, S_IMM_LO, S_IMM_HI, S_MEM, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, sp_q, sp_d;
    logic [7:0]  ir_q, ir_d, tmp_q, tmp_d, hi_q, hi_d;
    logic [3:0]  f_q, f_d;
    logic [7:0]  rf_q [8];
    logic [7:0]  rf_d [8];
    logic        halted_q, halted_d, retired_q, retired_d;

    logic [15:0] hl;
    logic        ir_a16_mem;
    logic [11:0] alu_out;
    logic [7:0]  alu_src;

    assign hl         = {rf_q[4], rf_q[5]};
    assign ir_a16_mem = (ir_q == 8'hEA) || (ir_q == 8'hFA);

    // Register file uses the opcode encoding: B C D E H L (HL) A; slot 6 is never written.
    function automatic state_t decode(input logic [7:0] op);
        state_t s;
        s = S_EXEC;
        if (op == 8'h01 || op == 8'h11 || op == 8'h21 || op == 8'h31 ||
            op == 8'hC3 || op == 8'hEA || op == 8'hFA)
            s = S_IMM_LO;
        else if (op[7:6] == 2'b00 && op[2:0] == 3'd6 && op[5:3] != 3'd6)
            s = S_IMM;
        else if (op[7:6] == 2'b11 && op[2:0] == 3'd6)
            s = S_IMM;
        else if (op == 8'h18 || op == 8'h20 || op == 8'h28 || op == 8'h30 || op == 8'h38)
            s = S_IMM;
        else if (op[7:6] == 2'b01 && op != 8'h76 && (op[2:0] == 3'd6 || op[5:3] == 3'd6))
            s = S_MEM;
        else if (op[7:6] == 2'b10 && op[2:0] == 3'd6)
            s = S_MEM;
        return s;
    endfunction

    // Returns {Z,N,H,C,result}; CP computes SUB flags, the caller drops the result.
    function automatic logic [11:0] alu(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic cy);
        logic [8:0] r9;
        logic [4:0] h5;
        logic [7:0] r;
        logic       n, h, c, ci;
        ci = ((op == 3'd1) || (op == 3'd3)) && cy;
        r9 = '0;
        h5 = '0;
        r  = '0;
        n  = 1'b0;
        h  = 1'b0;
        c  = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                r9 = {1'b0, a} + {1'b0, b} + {8'd0, ci};
                h5 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, ci};
                r = r9[7:0]; h = h5[4]; c = r9[8];
            end
            3'd2, 3'd3, 3'd7: begin
                r9 = {1'b0, a} - {1'b0, b} - {8'd0, ci};
                h5 = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, ci};
                r = r9[7:0]; n = 1'b1; h = h5[4]; c = r9[8];
            end
            3'd4: begin
                r = a & b; h = 1'b1;
            end
            3'd5: r = a ^ b;
            default: r = a | b;
        endcase
        return {(r == 8'h00), n, h, c, r};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = decode(mem_data_read);
            S_EXEC:   state_d = (ir_q == 8'h76) ? S_HALT : S_FETCH;
            S_IMM:    state_d = S_FETCH;
            S_IMM_LO: state_d = S_IMM_HI;
            S_IMM_HI: state_d = ir_a16_mem ? S_MEM : S_FETCH;
            S_MEM:    state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        mem_addr       = pc_q;
        mem_do_write   = 1'b0;
        mem_data_write = (ir_q == 8'hEA) ? rf_q[7] : rf_q[ir_q[2:0]];
        if (state_q == S_MEM) begin
            mem_addr     = ir_a16_mem ? {hi_q, tmp_q} : hl;
            mem_do_write = (ir_q == 8'hEA) || (ir_q[7:3] == 5'b01110 && ir_q != 8'h76);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            sp_q      <= RESET_SP;
            ir_q      <= '0;
            tmp_q     <= '0;
            hi_q      <= '0;
            f_q       <= '0;
            halted_q  <= 1'b0;
            retired_q <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            ir_q      <= ir_d;
            tmp_q     <= tmp_d;
            hi_q      <= hi_d;
            f_q       <= f_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            for (int unsigned i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
        end
    end

    always_comb begin
        alu_src = (state_q == S_EXEC) ? rf_q[ir_q[2:0]] : mem_data_read;
        alu_out = alu(ir_q[5:3], rf_q[7], alu_src, f_q[0]);
    end

    always_comb begin
        pc_d      = pc_q;
        sp_d      = sp_q;
        ir_d      = ir_q;
        tmp_d     = tmp_q;
        hi_d      = hi_q;
        f_d       = f_q;
        halted_d  = halted_q;
        retired_d = 1'b0;
        rf_d      = rf_q;
        case (state_q)
            S_FETCH: begin
                ir_d = mem_data_read;
                pc_d = pc_q + 16'd1;
            end
            S_EXEC: begin
                retired_d = 1'b1;
                if (ir_q == 8'h76) begin
                    halted_d = 1'b1;
                end else if (ir_q[7:6] == 2'b01) begin
                    rf_d[ir_q[5:3]] = rf_q[ir_q[2:0]];
                end else if (ir_q[7:6] == 2'b10) begin
                    f_d = alu_out[11:8];
                    if (ir_q[5:3] != 3'd7) rf_d[7] = alu_out[7:0];
                end else if (ir_q[7:6] == 2'b00 && ir_q[5:3] != 3'd6 && ir_q[2:1] == 2'b10) begin
                    if (!ir_q[0]) begin
                        rf_d[ir_q[5:3]] = rf_q[ir_q[5:3]] + 8'd1;
                        f_d = {(rf_q[ir_q[5:3]] == 8'hFF), 1'b0,
                               (rf_q[ir_q[5:3]][3:0] == 4'hF), f_q[0]};
                    end else begin
                        rf_d[ir_q[5:3]] = rf_q[ir_q[5:3]] - 8'd1;
                        f_d = {(rf_q[ir_q[5:3]] == 8'h01), 1'b1,
                               (rf_q[ir_q[5:3]][3:0] == 4'h0), f_q[0]};
                    end
                end
            end
            S_IMM: begin
                retired_d = 1'b1;
                pc_d = pc_q + 16'd1;
                if (ir_q[7:6] == 2'b00 && ir_q[2:0] == 3'd6) begin
                    rf_d[ir_q[5:3]] = mem_data_read;
                end else if (ir_q[7:6] == 2'b11) begin
                    f_d = alu_out[11:8];
                    if (ir_q[5:3] != 3'd7) rf_d[7] = alu_out[7:0];
                end else if (ir_q == 8'h18 ||
                             (ir_q[4:3] == 2'b00 && !f_q[3]) || (ir_q[4:3] == 2'b01 && f_q[3]) ||
                             (ir_q[4:3] == 2'b10 && !f_q[0]) || (ir_q[4:3] == 2'b11 && f_q[0])) begin
                    pc_d = pc_q + 16'd1 + {{8{mem_data_read[7]}}, mem_data_read};
                end
            end
            S_IMM_LO: begin
                tmp_d = mem_data_read;
                pc_d  = pc_q + 16'd1;
            end
            S_IMM_HI: begin
                pc_d = pc_q + 16'd1;
                if (ir_a16_mem) begin
                    hi_d = mem_data_read;
                end else begin
                    retired_d = 1'b1;
                    case (ir_q)
                        8'h01:   begin rf_d[0] = mem_data_read; rf_d[1] = tmp_q; end
                        8'h11:   begin rf_d[2] = mem_data_read; rf_d[3] = tmp_q; end
                        8'h21:   begin rf_d[4] = mem_data_read; rf_d[5] = tmp_q; end
                        8'h31:   sp_d = {mem_data_read, tmp_q};
                        default: pc_d = {mem_data_read, tmp_q};
                    endcase
                end
            end
            S_MEM: begin
                retired_d = 1'b1;
                if (ir_q == 8'hFA) begin
                    rf_d[7] = mem_data_read;
                end else if (ir_q[7:6] == 2'b01 && ir_q[2:0] == 3'd6) begin
                    rf_d[ir_q[5:3]] = mem_data_read;
                end else if (ir_q[7:6] == 2'b10) begin
                    f_d = alu_out[11:8];
                    if (ir_q[5:3] != 3'd7) rf_d[7] = alu_out[7:0];
                end
            end
            default: ;
        endcase
    end

    assign halted                  = halted_q;
    assign dbg_pc                  = pc_q;
    assign dbg_F                   = f_q;
    assign dbg_A                   = rf_q[7];
    assign dbg_B                   = rf_q[0];
    assign dbg_C                   = rf_q[1];
    assign dbg_instruction_retired = retired_q;

endmodule

// File: tb/tb_gb_cpu_core.sv
// Self-checking bench for gb_cpu_core: behavioural byte memory, retire/write scoreboards.
module tb_gb_cpu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_write;
    logic [7:0]  mem_data_read;
    logic        mem_do_write;
    logic        halted;
    logic [15:0] dbg_pc;
    logic [3:0]  dbg_F;
    logic [7:0]  dbg_A, dbg_B, dbg_C;
    logic        dbg_instruction_retired;

    logic [7:0]  mem [65536];
    logic [15:0] exp_pc_q [$];
    logic [23:0] exp_wr_q [$];
    int          errors = 0;
    int          checks = 0;
    int          retires = 0;
    int          writes = 0;

    gb_cpu_core #(.RESET_PC(16'h0000), .RESET_SP(16'hFFFE)) dut (
        .clk(clk),
        .reset(reset),
        .mem_addr(mem_addr),
        .mem_data_write(mem_data_write),
        .mem_data_read(mem_data_read),
        .mem_do_write(mem_do_write),
        .halted(halted),
        .dbg_pc(dbg_pc),
        .dbg_F(dbg_F),
        .dbg_A(dbg_A),
        .dbg_B(dbg_B),
        .dbg_C(dbg_C),
        .dbg_instruction_retired(dbg_instruction_retired)
    );

    always #5 clk = ~clk;

    assign mem_data_read = mem[mem_addr];

    // Program bytes are right-aligned in b: first byte is the most significant one.
    task automatic load(input int unsigned n, input logic [63:0] b);
        for (int unsigned i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int unsigned i = 0; i < n; i++) mem[i] = b[8*(n-1-i) +: 8];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_pc_q.delete();
        exp_wr_q.delete();
        retires = 0;
        writes = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic step();
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        logic [23:0] e;
        logic [15:0] p;
        w = mem_do_write;
        a = mem_addr;
        d = mem_data_write;
        if (w) begin
            writes++;
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL store: unexpected write addr=%h data=%h", a, d);
            end else begin
                e = exp_wr_q.pop_front();
                if ({a, d} !== e) begin
                    errors++;
                    $display("FAIL store: got addr/data=%h required %h", {a, d}, e);
                end
            end
        end
        @(posedge clk);
        if (w) mem[a] = d;
        #1;
        if (dbg_instruction_retired === 1'b1) begin
            retires++;
            checks++;
            if (exp_pc_q.size() == 0) begin
                errors++;
                $display("FAIL retire: unexpected retire pulse pc=%h", dbg_pc);
            end else begin
                p = exp_pc_q.pop_front();
                if (dbg_pc !== p) begin
                    errors++;
                    $display("FAIL retire_pc: got %h required %h", dbg_pc, p);
                end
            end
        end
    endtask

    task automatic run(input int unsigned max_cycles);
        int unsigned n;
        n = 0;
        while (halted !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles required 1", halted, n);
        end
        checks++;
        if (exp_pc_q.size() != 0) begin
            errors++;
            $display("FAIL retire_count: %0d expected retires missing, required 0", exp_pc_q.size());
        end
    endtask

    task automatic test_reset();
        load(1, 64'h76);
        do_reset();
        checks++; if (dbg_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h required 0000", dbg_pc); end
        checks++; if ({dbg_A, dbg_B, dbg_C} !== 24'h0) begin errors++; $display("FAIL reset_regs: got %h required 000000", {dbg_A, dbg_B, dbg_C}); end
        checks++; if (dbg_F !== 4'b0000) begin errors++; $display("FAIL reset_F: got %b required 0000", dbg_F); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
        checks++; if (mem_do_write !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b required 0", mem_do_write); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h required 0000", mem_addr); end
        checks++; if (dbg_instruction_retired !== 1'b0) begin errors++; $display("FAIL reset_retire: got %b required 0", dbg_instruction_retired); end
    endtask

    task automatic test_add_halt();
        load(6, 64'h3E0506038076);
        do_reset();
        exp_pc_q.push_back(16'h0002);
        exp_pc_q.push_back(16'h0004);
        exp_pc_q.push_back(16'h0005);
        exp_pc_q.push_back(16'h0006);
        run(50);
        checks++; if (dbg_A !== 8'h08) begin errors++; $display("FAIL add_A: got %h required 08", dbg_A); end
        checks++; if (dbg_B !== 8'h03) begin errors++; $display("FAIL add_B: got %h required 03", dbg_B); end
        checks++; if (dbg_F !== 4'b0000) begin errors++; $display("FAIL add_F: got %b required 0000", dbg_F); end
        for (int unsigned i = 0; i < 8; i++) step();
        checks++; if (retires != 4) begin errors++; $display("FAIL add_retires: got %0d required 4", retires); end
        checks++; if (dbg_pc !== 16'h0006) begin errors++; $display("FAIL halt_pc: got %h required 0006", dbg_pc); end
        checks++; if (mem_do_write !== 1'b0) begin errors++; $display("FAIL halt_wr: got %b required 0", mem_do_write); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b required 1", halted); end
    endtask

    task automatic test_alu_flags();
        load(5, 64'h3E0FC60176);
        do_reset();
        exp_pc_q.push_back(16'h0002);
        exp_pc_q.push_back(16'h0004);
        exp_pc_q.push_back(16'h0005);
        run(50);
        checks++; if (dbg_A !== 8'h10) begin errors++; $display("FAIL hc_A: got %h required 10", dbg_A); end
        checks++; if (dbg_F !== 4'b0010) begin errors++; $display("FAIL hc_F: got %b required 0010", dbg_F); end
        load(5, 64'h3EFFC60176);
        do_reset();
        exp_pc_q.push_back(16'h0002);
        exp_pc_q.push_back(16'h0004);
        exp_pc_q.push_back(16'h0005);
        run(50);
        checks++; if (dbg_A !== 8'h00) begin errors++; $display("FAIL wrap_A: got %h required 00", dbg_A); end
        checks++; if (dbg_F !== 4'b1011) begin errors++; $display("FAIL wrap_F: got %b required 1011", dbg_F); end
    endtask

    task automatic test_mem_store_load();
        load(8, 64'h2140003EAA774E76);
        do_reset();
        exp_pc_q.push_back(16'h0003);
        exp_pc_q.push_back(16'h0005);
        exp_pc_q.push_back(16'h0006);
        exp_pc_q.push_back(16'h0007);
        exp_pc_q.push_back(16'h0008);
        exp_wr_q.push_back({16'h0040, 8'hAA});
        run(50);
        checks++; if (writes != 1) begin errors++; $display("FAIL store_count: got %0d required 1", writes); end
        checks++; if (exp_wr_q.size() != 0) begin errors++; $display("FAIL store_missing: %0d pending required 0", exp_wr_q.size()); end
        checks++; if (mem[16'h0040] !== 8'hAA) begin errors++; $display("FAIL store_mem: got %h required AA", mem[16'h0040]); end
        checks++; if (dbg_C !== 8'hAA) begin errors++; $display("FAIL load_C: got %h required AA", dbg_C); end
    endtask

    task automatic test_jr_loop();
        load(6, 64'h06030520FD76);
        do_reset();
        exp_pc_q.push_back(16'h0002);
        for (int unsigned i = 0; i < 2; i++) begin
            exp_pc_q.push_back(16'h0003);
            exp_pc_q.push_back(16'h0002);
        end
        exp_pc_q.push_back(16'h0003);
        exp_pc_q.push_back(16'h0005);
        exp_pc_q.push_back(16'h0006);
        run(100);
        checks++; if (dbg_B !== 8'h00) begin errors++; $display("FAIL loop_B: got %h required 00", dbg_B); end
        checks++; if (dbg_F !== 4'b1100) begin errors++; $display("FAIL loop_F: got %b required 1100", dbg_F); end
        checks++; if (retires != 8) begin errors++; $display("FAIL loop_retires: got %0d required 8", retires); end
    endtask

    task automatic test_reset_mid();
        load(3, 64'h3E7776);
        do_reset();
        step();
        checks++; if (mem_addr !== 16'h0001) begin errors++; $display("FAIL mid_imm_addr: got %h required 0001", mem_addr); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dbg_A !== 8'h00) begin errors++; $display("FAIL mid_A: got %h required 00", dbg_A); end
        checks++; if (dbg_pc !== 16'h0000) begin errors++; $display("FAIL mid_pc: got %h required 0000", dbg_pc); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL mid_addr: got %h required 0000", mem_addr); end
        exp_pc_q.push_back(16'h0002);
        exp_pc_q.push_back(16'h0003);
        run(50);
        checks++; if (dbg_A !== 8'h77) begin errors++; $display("FAIL rerun_A: got %h required 77", dbg_A); end
    endtask

    initial begin
        test_reset();
        test_add_halt();
        test_alu_flags();
        test_mem_store_load();
        test_jr_loop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
